// File: rtl/range_seq_pkg.sv
// Shared types and constants for the range window sequencer.
// The stall limit is only used when RANGE_SEQ_TIMEOUT_EN is defined.
package range_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      SETTLE = 2'd2,
      RESULT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_LEN   = 2'd1,
      ERR_ABORT = 2'd2,
      ERR_DP    = 2'd3
   } err_t;

   localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

endpackage

// File: rtl/range_seq_watchdog.sv
// Stall counter for the accumulate phase; raises timeout on the stall cycle
// in which the count would reach the limit. Used only with RANGE_SEQ_TIMEOUT_EN.
module range_seq_watchdog
   import range_seq_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic active,
   input  logic beat,
   output logic timeout
);

   logic [15:0] stall_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (!active || beat) begin
         stall_cnt <= '0;
      end else if (stall_cnt != TIMEOUT_LIMIT) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   // Fire in the cycle whose stall would bring the count to the limit.
   assign timeout = active && !beat && (stall_cnt == TIMEOUT_LIMIT - 16'd1);

endmodule

// File: rtl/range_window_sequencer.sv
// Sequences fixed-length sample windows through the min/max range datapath.
// Optional stall timeout in ACCUM is enabled by defining RANGE_SEQ_TIMEOUT_EN.
module range_window_sequencer
   import range_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] win_len,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   output logic             s_ready,
   output logic [WIDTH-1:0] dp_data,
   output logic             dp_go,
   output logic             dp_finish,
   input  logic [WIDTH-1:0] dp_range,
   input  logic             dp_error,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_range,
   output logic [1:0]       err_code
);

   state_t           state, state_next;
   err_t             err, err_next;
   logic [CNT_W-1:0] remaining, remaining_next;
   logic             first, first_next;
   logic             accepted;
   logic             timeout;
   logic             len_ok;

   assign s_ready   = (state == ACCUM);
   assign accepted  = s_valid && s_ready;
   assign dp_data   = s_data;
   assign dp_go     = accepted && first;
   assign dp_finish = accepted && (remaining == CNT_W'(1));
   assign busy      = (state != IDLE);
   assign res_valid = (state == RESULT);
   assign err_code  = err;
   assign len_ok    = (win_len >= CNT_W'(2));

`ifdef RANGE_SEQ_TIMEOUT_EN
   range_seq_watchdog u_watchdog (
      .clock   (clock),
      .reset_n (reset_n),
      .active  (state == ACCUM),
      .beat    (accepted),
      .timeout (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         err       <= ERR_NONE;
         remaining <= '0;
         first     <= 1'b0;
         res_range <= '0;
      end else begin
         state     <= state_next;
         err       <= err_next;
         remaining <= remaining_next;
         first     <= first_next;
         if (state == SETTLE) begin
            res_range <= dp_range;
         end
      end
   end

   always_comb begin
      state_next     = state;
      err_next       = err;
      remaining_next = remaining;
      first_next     = first;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               if (len_ok) begin
                  state_next     = ACCUM;
                  remaining_next = win_len;
                  first_next     = 1'b1;
                  err_next       = ERR_NONE;
               end else begin
                  err_next = ERR_LEN;
               end
            end
         end
         ACCUM: begin
            if (abort || timeout) begin
               state_next     = IDLE;
               remaining_next = '0;
               first_next     = 1'b0;
               err_next       = ERR_ABORT;
            end else if (accepted) begin
               remaining_next = remaining - CNT_W'(1);
               first_next     = 1'b0;
               if (remaining == CNT_W'(1)) begin
                  state_next = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (abort) begin
               state_next = IDLE;
               err_next   = ERR_ABORT;
            end else begin
               state_next = RESULT;
            end
         end
         RESULT: begin
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // A datapath error outranks every other cause raised in the same cycle.
      if (dp_error && busy) begin
         err_next = ERR_DP;
      end
   end

endmodule

// File: tb/tb_range_window_sequencer.sv
// Self-checking bench for range_window_sequencer with a behavioural window model.
// Also exercises the RANGE_SEQ_TIMEOUT_EN build when that macro is defined.
module tb_range_window_sequencer;

   localparam int WIDTH = 16;
   localparam int CNT_W = 8;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] win_len = '0;
   logic             s_valid = 1'b0;
   logic [WIDTH-1:0] s_data = '0;
   logic             s_ready;
   logic [WIDTH-1:0] dp_data;
   logic             dp_go;
   logic             dp_finish;
   logic [WIDTH-1:0] dp_range;
   logic             dp_error = 1'b0;
   logic             busy;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [WIDTH-1:0] res_range;
   logic [1:0]       err_code;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 clock = ~clock;

   range_window_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .win_len   (win_len),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .dp_data   (dp_data),
      .dp_go     (dp_go),
      .dp_finish (dp_finish),
      .dp_range  (dp_range),
      .dp_error  (dp_error),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_range (res_range),
      .err_code  (err_code)
   );

   // Stand-in min/max datapath driven by the sequencer's go strobe.
   logic [WIDTH-1:0] dp_min, dp_max;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dp_min <= '0;
         dp_max <= '0;
      end else if (dp_go) begin
         dp_min <= dp_data;
         dp_max <= dp_data;
      end else if (s_valid && s_ready) begin
         if (dp_data < dp_min) dp_min <= dp_data;
         if (dp_data > dp_max) dp_max <= dp_data;
      end
   end
   assign dp_range = dp_max - dp_min;

   // Window model: counts beats, tracks sample extremes, and applies error rules.
   logic             m_open, m_settle, m_result;
   int               m_left, m_taken, m_min, m_max, m_stall;
   logic [WIDTH-1:0] m_range;
   logic [1:0]       m_err;
   logic             m_busy;
   logic             stall_timeout;

   assign m_busy = m_open || m_settle || m_result;
`ifdef RANGE_SEQ_TIMEOUT_EN
   assign stall_timeout = m_open && !s_valid && (m_stall == 65534);
`else
   assign stall_timeout = 1'b0;
`endif

   function automatic logic [1:0] model_err();
      if (dp_error && m_busy) return 2'd3;
      if ((m_open || m_settle) && (abort || stall_timeout)) return 2'd2;
      if (!m_busy && start && !abort) return (win_len >= 2) ? 2'd0 : 2'd1;
      return m_err;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_open <= 1'b0; m_settle <= 1'b0; m_result <= 1'b0;
         m_left <= 0; m_taken <= 0; m_min <= 0; m_max <= 0; m_stall <= 0;
         m_range <= '0; m_err <= 2'd0;
      end else begin
         if (m_open) begin
            m_stall <= s_valid ? 0 : m_stall + 1;
            if (abort || stall_timeout) begin
               m_open <= 1'b0;
            end else if (s_valid) begin
               m_taken <= m_taken + 1;
               m_left  <= m_left - 1;
               m_min   <= (m_taken == 0 || int'(s_data) < m_min) ? int'(s_data) : m_min;
               m_max   <= (m_taken == 0 || int'(s_data) > m_max) ? int'(s_data) : m_max;
               if (m_left == 1) begin
                  m_open   <= 1'b0;
                  m_settle <= 1'b1;
               end
            end
         end else if (m_settle) begin
            m_settle <= 1'b0;
            if (!abort) begin
               m_result <= 1'b1;
               m_range  <= WIDTH'(m_max - m_min);
            end
         end else if (m_result) begin
            if (res_ready) m_result <= 1'b0;
         end else if (start && !abort && win_len >= 2) begin
            m_open  <= 1'b1;
            m_left  <= int'(win_len);
            m_taken <= 0;
            m_stall <= 0;
         end
         m_err <= model_err();
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      chk_cnt++;
      if (actual === expected) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s: actual %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle, compare all DUT outputs with the model.
   always @(negedge clock) begin
      check_output("s_ready", 32'(s_ready), 32'(m_open));
      check_output("busy", 32'(busy), 32'(m_busy));
      check_output("res_valid", 32'(res_valid), 32'(m_result));
      check_output("err_code", 32'(err_code), 32'(m_err));
      check_output("dp_data", 32'(dp_data), 32'(s_data));
      check_output("dp_go", 32'(dp_go), 32'(m_open && s_valid && m_taken == 0));
      check_output("dp_finish", 32'(dp_finish), 32'(m_open && s_valid && m_left == 1));
      if (m_result) check_output("res_range", 32'(res_range), 32'(m_range));
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_stimulus(input logic st, input logic [CNT_W-1:0] wl, input logic sv, input logic [WIDTH-1:0] sd);
      start   = st;
      win_len = wl;
      s_valid = sv;
      s_data  = sd;
      step();
   endtask

   task automatic take_result(input string tag, input int exp_range, input int exp_err);
      int n;
      n = 0;
      @(negedge clock);
      while (!res_valid && n < 50) begin
         @(negedge clock);
         n++;
      end
      check_output({tag, "_result_seen"}, 32'(n < 50), 32'd1);
      check_output({tag, "_range"}, 32'(res_range), 32'(exp_range));
      check_output({tag, "_err"}, 32'(err_code), 32'(exp_err));
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      @(negedge clock);
      check_output({tag, "_idle_after"}, 32'(busy), 32'd0);
      step();
   endtask

   initial begin
      int lat, beats, fin_cnt, fin_beat, rv_cnt, stable_cnt;
      logic [WIDTH-1:0] samples [4];
      samples[0] = 16'd7; samples[1] = 16'd3; samples[2] = 16'd9; samples[3] = 16'd5;

      repeat (2) @(posedge clock);
      @(negedge clock);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_s_ready", 32'(s_ready), 32'd0);
      check_output("rst_res_valid", 32'(res_valid), 32'd0);
      check_output("rst_res_range", 32'(res_range), 32'd0);
      check_output("rst_err", 32'(err_code), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      step();

      // Four samples back to back: range 9-3 after six cycles.
      $display("[TB] window of 4, continuous valid");
      apply_stimulus(1'b1, 8'd4, 1'b0, '0);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = samples[i];
         @(negedge clock);
         check_output("w4_go", 32'(dp_go), 32'(i == 0));
         check_output("w4_finish", 32'(dp_finish), 32'(i == 3));
         step();
      end
      s_valid = 1'b0;
      lat = 4;
      while (!res_valid && lat < 30) begin
         @(negedge clock);
         lat++;
      end
      check_output("w4_latency", 32'(lat), 32'd6);
      take_result("w4", 6, 0);

      // Gapped valid: only three beats taken, finish once on the third.
      $display("[TB] window of 3, gapped valid");
      apply_stimulus(1'b1, 8'd3, 1'b0, '0);
      start = 1'b0;
      beats = 0; fin_cnt = 0; fin_beat = 0;
      for (int i = 0; i < 8; i++) begin
         s_valid = (i % 2 == 1);
         s_data  = WIDTH'(20 + 5 * i);
         @(negedge clock);
         if (s_valid && s_ready) beats++;
         if (dp_finish) begin
            fin_cnt++;
            fin_beat = beats;
         end
         step();
      end
      s_valid = 1'b0;
      check_output("w3_beats", 32'(beats), 32'd3);
      check_output("w3_finish_cnt", 32'(fin_cnt), 32'd1);
      check_output("w3_finish_beat", 32'(fin_beat), 32'd3);
      take_result("w3", 20, 0);

      // Bad lengths are rejected; a valid start clears the error.
      $display("[TB] bad window lengths");
      apply_stimulus(1'b1, 8'd1, 1'b0, '0);
      start = 1'b0;
      @(negedge clock);
      check_output("len1_busy", 32'(busy), 32'd0);
      check_output("len1_err", 32'(err_code), 32'd1);
      step();
      apply_stimulus(1'b1, 8'd0, 1'b0, '0);
      start = 1'b0;
      @(negedge clock);
      check_output("len0_busy", 32'(busy), 32'd0);
      check_output("len0_err", 32'(err_code), 32'd1);
      step();
      apply_stimulus(1'b1, 8'd2, 1'b0, '0);
      start = 1'b0;
      @(negedge clock);
      check_output("len2_err_clear", 32'(err_code), 32'd0);
      check_output("len2_busy", 32'(busy), 32'd1);
      step();
      apply_stimulus(1'b0, 8'd2, 1'b1, 16'd100);
      apply_stimulus(1'b0, 8'd2, 1'b1, 16'd90);
      s_valid = 1'b0;
      take_result("len2", 10, 0);

      // Abort after two of five beats.
      $display("[TB] abort mid-window");
      apply_stimulus(1'b1, 8'd5, 1'b0, '0);
      apply_stimulus(1'b0, 8'd5, 1'b1, 16'd11);
      apply_stimulus(1'b0, 8'd5, 1'b1, 16'd12);
      s_valid = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      @(negedge clock);
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_s_ready", 32'(s_ready), 32'd0);
      check_output("abort_err", 32'(err_code), 32'd2);
      rv_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (res_valid) rv_cnt++;
      end
      check_output("abort_no_result", 32'(rv_cnt), 32'd0);
      step();

      // Stalled consumer: result stays put while start and abort are ignored.
      $display("[TB] result backpressure");
      apply_stimulus(1'b1, 8'd2, 1'b0, '0);
      apply_stimulus(1'b0, 8'd2, 1'b1, 16'd50);
      apply_stimulus(1'b0, 8'd2, 1'b1, 16'd80);
      s_valid = 1'b0;
      step();
      @(negedge clock);
      check_output("bp_valid", 32'(res_valid), 32'd1);
      stable_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         start   = 1'b1;
         win_len = 8'd4;
         abort   = (i >= 6);
         @(negedge clock);
         if (res_valid && res_range == 16'd30) stable_cnt++;
      end
      check_output("bp_stable", 32'(stable_cnt), 32'd10);
      step();
      start = 1'b0;
      abort = 1'b0;
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      @(negedge clock);
      check_output("bp_idle_after", 32'(busy), 32'd0);
      step();
      @(negedge clock);
      check_output("bp_start_not_queued", 32'(busy), 32'd0);
      step();

      // Datapath error is sticky, the result still arrives.
      $display("[TB] datapath error");
      apply_stimulus(1'b1, 8'd3, 1'b0, '0);
      apply_stimulus(1'b0, 8'd3, 1'b1, 16'd1);
      dp_error = 1'b1;
      apply_stimulus(1'b0, 8'd3, 1'b1, 16'd4);
      dp_error = 1'b0;
      apply_stimulus(1'b0, 8'd3, 1'b1, 16'd2);
      s_valid = 1'b0;
      take_result("dperr", 3, 3);

      // Datapath error and abort together: the datapath error wins.
      apply_stimulus(1'b1, 8'd4, 1'b0, '0);
      apply_stimulus(1'b0, 8'd4, 1'b1, 16'd5);
      s_valid  = 1'b0;
      abort    = 1'b1;
      dp_error = 1'b1;
      step();
      abort    = 1'b0;
      dp_error = 1'b0;
      @(negedge clock);
      check_output("prio_busy", 32'(busy), 32'd0);
      check_output("prio_err", 32'(err_code), 32'd3);
      step();

      // Asynchronous reset mid-window takes effect between clock edges.
      $display("[TB] asynchronous reset mid-window");
      apply_stimulus(1'b1, 8'd4, 1'b0, '0);
      apply_stimulus(1'b0, 8'd4, 1'b1, 16'd8);
      s_valid = 1'b0;
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check_output("arst_busy", 32'(busy), 32'd0);
      check_output("arst_s_ready", 32'(s_ready), 32'd0);
      check_output("arst_err", 32'(err_code), 32'd0);
      step();
      reset_n = 1'b1;
      step();

      // Stall with one beat delivered.
      $display("[TB] stalled window");
      apply_stimulus(1'b1, 8'd4, 1'b0, '0);
      apply_stimulus(1'b0, 8'd4, 1'b1, 16'd9);
      s_valid = 1'b0;
`ifdef RANGE_SEQ_TIMEOUT_EN
      repeat (65534) @(posedge clock);
      #1;
      @(negedge clock);
      check_output("tmo_still_busy", 32'(busy), 32'd1);
      step();
      @(negedge clock);
      check_output("tmo_busy", 32'(busy), 32'd0);
      check_output("tmo_err", 32'(err_code), 32'd2);
      step();
`else
      repeat (300) step();
      @(negedge clock);
      check_output("stall_busy", 32'(busy), 32'd1);
      check_output("stall_s_ready", 32'(s_ready), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      @(negedge clock);
      check_output("stall_abort_err", 32'(err_code), 32'd2);
      step();
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
